// File: rtl/mod_exp_pkg.sv
// Shared types for the modular exponentiation unit: FSM states and the operand
// width derived from the architecture half-width.
package mod_exp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        STEP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int op_width(input int arq);
        return 2 * arq;
    endfunction

endpackage

// File: rtl/mod_exp_mod_mult.sv
// Interleaved shift-add modular multiplier: product = a*x mod m, one multiplier
// bit per cycle, MSB first. The first bit is consumed on the start edge, so
// the product is ready after exactly W edges and done pulses for one cycle.
module mod_mult #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] x,
    input  logic [W-1:0] m,
    output logic         done,
    output logic [W-1:0] product
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  acc;
    logic [W-1:0]  a_r;
    logic [W-1:0]  m_r;
    logic [W-1:0]  xs;
    logic [CW-1:0] cnt;
    logic          busy;

    // acc < m on entry, so 2*acc and acc+a both stay below 2m and fit in W+1
    // bits; one conditional subtraction restores acc < m each time.
    function automatic logic [W-1:0] mstep(input logic [W-1:0] acc_in,
                                           input logic         xbit,
                                           input logic [W-1:0] a_in,
                                           input logic [W-1:0] m_in);
        logic [W:0] t;
        t = {acc_in, 1'b0};
        if (t >= {1'b0, m_in}) t = t - {1'b0, m_in};
        if (xbit) begin
            t = t + {1'b0, a_in};
            if (t >= {1'b0, m_in}) t = t - {1'b0, m_in};
        end
        return t[W-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            a_r  <= '0;
            m_r  <= '0;
            xs   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc  <= mstep('0, x[W-1], a, m);
                a_r  <= a;
                m_r  <= m;
                xs   <= {x[W-2:0], 1'b0};
                cnt  <= CW'(W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= mstep(acc, xs[W-1], a_r, m_r);
                xs  <= {xs[W-2:0], 1'b0};
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/mod_exp.sv
// Right-to-left square-and-multiply modular exponentiation. Starts on reset
// release, latches operands once, and holds the result with finish high.
module mod_exp
    import mod_exp_pkg::*;
#(
    parameter int ARQ = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2*ARQ-1:0] base,
    input  logic [2*ARQ-1:0] modulo,
    input  logic [2*ARQ-1:0] exponent,
    output logic             finish,
    output logic [2*ARQ-1:0] result
);
    localparam int W  = op_width(ARQ);
    localparam int IW = $clog2(W);

    state_t        state, state_nxt;
    logic [W-1:0]  base_r, mod_r, exp_r;
    logic [W-1:0]  b, r;
    logic [IW-1:0] bit_idx;
    logic          mult_go;

    logic          mul_start, sq_start;
    logic          mul_done, sq_done;
    logic [W-1:0]  mul_a, mul_x, mul_p, sq_p;
    logic          last_bit, step_done;

    // The multiplier instance doubles as the base reducer (1*base mod m).
    assign mul_a     = (state == REDUCE) ? W'(1) : r;
    assign mul_x     = (state == REDUCE) ? base_r : b;
    assign mul_start = mult_go;
    assign sq_start  = mult_go && (state == STEP);
    assign last_bit  = (bit_idx == IW'(W - 1));
    assign step_done = mul_done && sq_done;

    mod_mult #(.W(W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (mul_a),
        .x       (mul_x),
        .m       (mod_r),
        .done    (mul_done),
        .product (mul_p)
    );

    mod_mult #(.W(W)) u_sq (
        .clk     (clk),
        .reset   (reset),
        .start   (sq_start),
        .a       (b),
        .x       (b),
        .m       (mod_r),
        .done    (sq_done),
        .product (sq_p)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (modulo == '0) ? DONE : REDUCE;
            REDUCE:  if (mul_done) state_nxt = STEP;
            STEP:    if (step_done && last_bit) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_r  <= '0;
            mod_r   <= '0;
            exp_r   <= '0;
            b       <= '0;
            r       <= '0;
            bit_idx <= '0;
            mult_go <= 1'b0;
            finish  <= 1'b0;
            result  <= '0;
        end else begin
            mult_go <= 1'b0;
            case (state)
                IDLE: begin
                    base_r  <= base;
                    mod_r   <= modulo;
                    exp_r   <= exponent;
                    mult_go <= (modulo != '0);
                end
                REDUCE: if (mul_done) begin
                    b       <= mul_p;
                    r       <= (mod_r == W'(1)) ? '0 : W'(1);
                    bit_idx <= '0;
                    mult_go <= 1'b1;
                end
                STEP: if (step_done) begin
                    b <= sq_p;
                    if (exp_r[bit_idx]) r <= mul_p;
                    // Publish on the final update edge so result is valid as DONE is entered.
                    if (last_bit) begin
                        finish <= 1'b1;
                        result <= exp_r[bit_idx] ? mul_p : r;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        mult_go <= 1'b1;
                    end
                end
                DONE: begin
                    finish <= 1'b1;
                    result <= r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp.sv
// Self-checking bench for mod_exp: directed vector table, random operands vs a
// plain-arithmetic model, latency/stability checks and asynchronous reset cases.
module tb_mod_exp;
    localparam int ARQ = 16;
    localparam int W   = 2 * ARQ;
    localparam int LAT = 1 + W + W * (W + 1);

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] base = '0, modulo = '0, exponent = '0;
    logic         finish;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_exp #(.ARQ(ARQ)) dut (
        .clk      (clk),
        .reset    (reset),
        .base     (base),
        .modulo   (modulo),
        .exponent (exponent),
        .finish   (finish),
        .result   (result)
    );

    typedef struct {
        logic [31:0] b;
        logic [31:0] m;
        logic [31:0] e;
        logic [31:0] r;
    } vec_t;

    function automatic logic [31:0] model(input logic [31:0] b, input logic [31:0] m,
                                          input logic [31:0] e);
        longint unsigned mm, bb, rr;
        if (m == 0) return 32'd0;
        mm = longint'(m);
        bb = longint'(b) % mm;
        rr = 64'd1 % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) rr = (rr * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return rr[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, req, req);
        end
    endtask

    // Full run: async reset, operands latched at edge 0, inputs scrambled
    // afterwards, finish must rise exactly at the fixed latency and then hold.
    task automatic run(input logic [31:0] b, input logic [31:0] m, input logic [31:0] e,
                       input logic [31:0] req, input string name);
        int lat;
        logic [31:0] held;
        reset = 1'b0;
        base = b; modulo = m; exponent = e;
        #1;
        check({name, " rst finish"}, {31'd0, finish}, 32'd0);
        check({name, " rst result"}, result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        lat = (m == 0) ? 1 : LAT;
        @(posedge clk);
        #1;
        base = $urandom; modulo = $urandom; exponent = $urandom;
        repeat (lat - 1) @(posedge clk);
        #1;
        check({name, " early finish"}, {31'd0, finish}, 32'd0);
        @(posedge clk);
        #1;
        check({name, " finish"}, {31'd0, finish}, 32'd1);
        check({name, " result"}, result, req);
        held = result;
        repeat (5) @(posedge clk);
        #1;
        check({name, " hold finish"}, {31'd0, finish}, 32'd1);
        check({name, " hold result"}, result, held);
    endtask

    initial begin
        vec_t vecs[$];
        logic [31:0] rb, rm, re;

        #2;
        check("power-on finish", {31'd0, finish}, 32'd0);
        check("power-on result", result, 32'd0);

        vecs.push_back('{32'd255, 32'd1927, 32'd1842, 32'd1434});
        vecs.push_back('{32'd4, 32'd497, 32'd13, 32'd445});
        vecs.push_back('{32'd5, 32'd7, 32'd0, 32'd1});
        vecs.push_back('{32'd2000, 32'd1927, 32'd1, 32'd73});
        vecs.push_back('{32'd12345, 32'd1, 32'd99, 32'd0});
        vecs.push_back('{32'd77, 32'd0, 32'd5, 32'd0});
        vecs.push_back('{32'd0, 32'd13, 32'd0, 32'd1});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{32'd2, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd1});

        foreach (vecs[i]) run(vecs[i].b, vecs[i].m, vecs[i].e, vecs[i].r, $sformatf("vec%0d", i));

        // Reset mid-STEP, then restart with new operands.
        reset = 1'b0;
        base = 32'd255; modulo = 32'd1927; exponent = 32'd1842;
        @(negedge clk);
        reset = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        check("midstep finish", {31'd0, finish}, 32'd0);
        run(32'd3, 32'd13, 32'd5, 32'd9, "after midstep reset");

        for (int i = 0; i < 12; i++) begin
            rb = $urandom;
            re = $urandom;
            rm = (i % 3 == 0) ? $urandom_range(1, 1000) : $urandom;
            run(rb, rm, re, model(rb, rm, re), $sformatf("rand%0d", i));
        end

        // Reset after completion must clear outputs without a clock edge.
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async clear finish", {31'd0, finish}, 32'd0);
        check("async clear result", result, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
